fsm_controller_mc: RTL
======================

# fsm_controller_mc

Parametrised multi-channel, multi-byte controller for the ring-oscillator temperature-sensor datapath. It decodes UART command bytes, selects the active oscillator channel, enables the accumulator (`sum_en`) and streams an N-byte result through the UART transmitter. It supports single-shot and continuous acquisition and queues one pending command while a frame is in flight. It sits between `uart_rx`/`uart_tx`, the sum/counter block and the byte-select mux.

## Interface
- `N_BYTES`, 2: bytes per result frame, range 1..8.
- `GAP_CYCLES`, 100: minimum idle cycles after each `tx_send` before the next byte, range 1..2^TIMER_W-2.
- `TIMER_W`, 16: gap timer width.
- `N_CH`, 4: number of oscillator channels, range 1..16.
- Derived localparams: `SEL_W` = max(1, clog2(N_BYTES)); `CH_W` = max(1, clog2(N_CH)).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sum_ready`  in  1  accumulator result valid.
- `tx_busy`  in  1  UART transmitter busy.
- `rx_ready`  in  1  one-cycle pulse: `rx_data` valid.
- `rx_data`  in  8  received command byte.
- `sum_en`  out  1  accumulator enable.
- `tx_send`  out  1  one-cycle UART send strobe.
- `send_sel`  out  SEL_W  byte index presented to the UART mux.
- `ch_sel`  out  CH_W  active oscillator channel.
- `cont_mode`  out  1  1 = continuous acquisition, 0 = single-shot.
- `cmd_err`  out  1  one-cycle pulse on an unrecognised or out-of-range command.

## Operation
- Command capture:
  - On `rx_ready`=1, `cmd` <= `rx_data` and `pend` <= 1. A newer byte overwrites an unprocessed one; newest wins.
  - DECODE clears `pend`. If `rx_ready` arrives in the same cycle, the set wins.
- States: IDLE, DECODE, WAIT_SUM, SEND, WAIT_SEND.
- IDLE: if `pend`, go to DECODE.
- DECODE, one cycle:
  - 0x00: `cont_mode`<=1, go to WAIT_SUM.
  - 0x01: `cont_mode`<=0, go to WAIT_SUM.
  - 0x02: `cont_mode`<=0, go to IDLE (stop).
  - 0x10+k with k<N_CH: `ch_sel`<=k, go to IDLE. Acquisition stops; a channel change always needs a restart.
  - Anything else (including 0x10+k with k>=N_CH): `cmd_err`=1 for this cycle, go to IDLE, registers unchanged.
- WAIT_SUM:
  - `sum_en`=1.
  - If `pend`, go to DECODE (abort; priority over `sum_ready`).
  - Else if `sum_ready`, `byte_idx`<=0 and go to SEND.
- SEND: `tx_send`=1 and `send_sel`=`byte_idx`, then go to WAIT_SEND.
- WAIT_SEND:
  - `send_sel`=`byte_idx`.
  - Exit when `timer` >= GAP_CYCLES and `tx_busy`=0.
  - If `byte_idx` < N_BYTES-1: increment `byte_idx`, go to SEND.
  - Else, in priority order: `pend` → DECODE; `cont_mode` → WAIT_SUM; otherwise → IDLE.
- Commands arriving during SEND/WAIT_SEND never truncate a frame; they are handled after the last byte.
- Timer:
  - Cleared on the edge that changes state; otherwise increments each cycle.
  - Saturates at all-ones.
- Output defaults: `sum_en`, `tx_send`, `cmd_err`=0 and `send_sel`=0 in every state not listed above. `sum_en`=0 during SEND/WAIT_SEND.
- Reset (asserted, async): state=IDLE; `sum_en`, `tx_send`, `send_sel`, `ch_sel`, `cont_mode`, `cmd_err`=0; `pend`, `timer`, `byte_idx`=0. Mid-frame reset aborts immediately with no further `tx_send`.

## Timing
- `rx_ready` high at edge n: `pend`=1 after n; DECODE during cycle n+1→n+2; `ch_sel`/`cont_mode` updated at edge n+2.
- `sum_ready` seen in WAIT_SUM at edge m: `tx_send` high during the next cycle.
- With `tx_busy`=0:
  - WAIT_SEND lasts GAP_CYCLES+1 cycles.
  - Consecutive `tx_send` pulses are GAP_CYCLES+2 cycles apart.
  - Frame = N_BYTES*(GAP_CYCLES+2) cycles.
- `tx_busy` held high extends WAIT_SEND indefinitely; exit is on the first cycle with `tx_busy`=0 and timer >= GAP_CYCLES.
- `cmd_err` and `tx_send` are single-cycle pulses, registered-state decoded, with no combinational path from `rx_data`.

## Test plan
- Reset, then 0x01 with `sum_ready` pulsed: exactly N_BYTES=2 `tx_send` pulses with `send_sel` 0 then 1, spaced 102 cycles; FSM returns to IDLE with `sum_en`=0.
- 0x00 with `sum_ready` pulsed three times: three complete frames; `sum_en`=1 between frames, `cont_mode`=1.
- 0x13 with N_CH=4: `ch_sel`=3, no `cmd_err`. Then 0x14: one-cycle `cmd_err`, `ch_sel` stays 3. Then 0x7F: `cmd_err`.
- 0x02 sent during byte 0 of a continuous frame: byte 1 still sent; FSM then goes DECODE → IDLE with `cont_mode`=0.
- `tx_busy` held high for 300 cycles after the first `tx_send`: the second `tx_send` occurs one cycle after `tx_busy` falls. `rx_ready` coinciding with DECODE leaves `pend`=1.
- `reset` asserted mid-WAIT_SEND: all outputs 0 asynchronously; no `tx_send` after release until a new command.

Source files
------------

// File: rtl/fsm_controller_mc_if.sv
// Command/acquisition/UART handshake bundle between the temperature-sensor
// controller (master side) and the surrounding datapath (slave side).
interface fsm_controller_mc_if #(
   parameter int N_BYTES = 2,
   parameter int N_CH    = 4
);
   localparam int SEL_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             sum_ready;
   logic             tx_busy;
   logic             rx_ready;
   logic [7:0]       rx_data;
   logic             sum_en;
   logic             tx_send;
   logic [SEL_W-1:0] send_sel;
   logic [CH_W-1:0]  ch_sel;
   logic             cont_mode;
   logic             cmd_err;

   modport master (
      input  sum_ready, tx_busy, rx_ready, rx_data,
      output sum_en, tx_send, send_sel, ch_sel, cont_mode, cmd_err
   );

   modport slave (
      output sum_ready, tx_busy, rx_ready, rx_data,
      input  sum_en, tx_send, send_sel, ch_sel, cont_mode, cmd_err
   );
endinterface

// File: rtl/fsm_controller_mc.sv
// Multi-channel ring-oscillator sensor controller: decodes UART commands,
// gates the accumulator and streams an N_BYTES result frame with paced sends.
module fsm_controller_mc #(
   parameter int N_BYTES    = 2,
   parameter int GAP_CYCLES = 100,
   parameter int TIMER_W    = 16,
   parameter int N_CH       = 4
) (
   input logic                 clk,
   input logic                 reset,
   fsm_controller_mc_if.master bus
);
   localparam int SEL_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(N_BYTES - 1);
   localparam logic [TIMER_W-1:0] GAP_T    = TIMER_W'(GAP_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      WAIT_SUM,
      SEND,
      WAIT_SEND
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [7:0]         cmd;
   logic               pend;
   logic [TIMER_W-1:0] timer;
   logic [SEL_W-1:0]   byte_idx;
   logic [CH_W-1:0]    ch_reg;
   logic               cont_reg;

   logic               sum_en;
   logic               tx_send;
   logic               cmd_err;
   logic [SEL_W-1:0]   send_sel;
   logic               pend_clr;
   logic               byte_clr;
   logic               byte_inc;
   logic               ch_load;
   logic               cont_load;
   logic               cont_val;
   logic               ch_cmd;
   logic               gap_done;

   // 0x10+k selects channel k only when that channel exists
   assign ch_cmd   = (cmd[7:4] == 4'h1) && (int'({28'd0, cmd[3:0]}) < N_CH);
   assign gap_done = (timer >= GAP_T) && !bus.tx_busy;

   // Next-state and Moore outputs; all strobes decode registered state only
   always_comb begin
      state_next = state;
      sum_en     = 1'b0;
      tx_send    = 1'b0;
      cmd_err    = 1'b0;
      send_sel   = '0;
      pend_clr   = 1'b0;
      byte_clr   = 1'b0;
      byte_inc   = 1'b0;
      ch_load    = 1'b0;
      cont_load  = 1'b0;
      cont_val   = 1'b0;
      case (state)
         IDLE: begin
            if (pend) state_next = DECODE;
         end
         DECODE: begin
            pend_clr   = 1'b1;
            state_next = IDLE;
            case (cmd)
               8'h00: begin
                  cont_load  = 1'b1;
                  cont_val   = 1'b1;
                  state_next = WAIT_SUM;
               end
               8'h01: begin
                  cont_load  = 1'b1;
                  state_next = WAIT_SUM;
               end
               8'h02: begin
                  cont_load = 1'b1;
               end
               default: begin
                  if (ch_cmd) ch_load = 1'b1;
                  else        cmd_err = 1'b1;
               end
            endcase
         end
         WAIT_SUM: begin
            sum_en = 1'b1;
            // A new command aborts the acquisition before a result is taken
            if (pend) begin
               state_next = DECODE;
            end else if (bus.sum_ready) begin
               byte_clr   = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            tx_send    = 1'b1;
            send_sel   = byte_idx;
            state_next = WAIT_SEND;
         end
         WAIT_SEND: begin
            send_sel = byte_idx;
            if (gap_done) begin
               if (byte_idx < LAST_IDX) begin
                  byte_inc   = 1'b1;
                  state_next = SEND;
               end else if (pend) begin
                  state_next = DECODE;
               end else if (cont_reg) begin
                  state_next = WAIT_SUM;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Newest byte wins; a byte landing during DECODE keeps pend set
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd  <= 8'h00;
         pend <= 1'b0;
      end else begin
         if (bus.rx_ready) begin
            cmd  <= bus.rx_data;
            pend <= 1'b1;
         end else if (pend_clr) begin
            pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer <= '0;
      end else if (state_next != state) begin
         timer <= '0;
      end else if (timer != '1) begin
         timer <= timer + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_idx <= '0;
         ch_reg   <= '0;
         cont_reg <= 1'b0;
      end else begin
         if (byte_clr)      byte_idx <= '0;
         else if (byte_inc) byte_idx <= byte_idx + SEL_W'(1);
         if (ch_load)   ch_reg   <= cmd[CH_W-1:0];
         if (cont_load) cont_reg <= cont_val;
      end
   end

   assign bus.sum_en    = sum_en;
   assign bus.tx_send   = tx_send;
   assign bus.send_sel  = send_sel;
   assign bus.ch_sel    = ch_reg;
   assign bus.cont_mode = cont_reg;
   assign bus.cmd_err   = cmd_err;

   // Send and error strobes must never stretch past one cycle
   assert property (@(posedge clk) disable iff (!reset) tx_send |=> !tx_send);
   assert property (@(posedge clk) disable iff (!reset) cmd_err |=> !cmd_err);
endmodule
